instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer_pkg.sv | 33 +++
 rtl/instruction_sequencer_if.sv | 29 ++
 rtl/instruction_sequencer_word_counter.sv | 29 ++
 rtl/instruction_sequencer.sv | 127 ++++++++++++
 tb/tb_instruction_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared types for the instruction sequencer: FSM state encoding and the
// 3-bit instruction codes understood by the downstream instruction decoder.
package instr_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_CR,
        S_LD_ADDR,
        S_LD_WORD,
        S_OUT,
        S_STEP,
        S_FIN
    } seq_state_e;

    localparam logic [2:0] I_LDCR = 3'b000;
    localparam logic [2:0] I_OUTA = 3'b001;
    localparam logic [2:0] I_OUTB = 3'b010;
    localparam logic [2:0] I_OUTC = 3'b011;
    localparam logic [2:0] I_LDWC = 3'b100;
    localparam logic [2:0] I_LDAR = 3'b101;
    localparam logic [2:0] I_LDWR = 3'b110;
    localparam logic [2:0] I_STEP = 3'b111;

    // Output-source select to instruction code; 00 aliases to source A.
    function automatic logic [2:0] sel_to_code(input logic [1:0] sel);
        case (sel)
            2'b10:   return I_OUTB;
            2'b11:   return I_OUTC;
            default: return I_OUTA;
        endcase
    endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Command handshake plus decoder-facing outputs of the instruction sequencer.
// master = command issuer / observer, slave = the sequencer itself.
interface instruction_sequencer_if #(parameter int DW = 8);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_cr;
    logic [DW-1:0] cmd_addr;
    logic [DW-1:0] cmd_count;
    logic [1:0]    cmd_sel;
    logic          abort;

    logic [2:0]    i;
    logic          i_en;
    logic [DW-1:0] load_data;
    logic          busy;
    logic          done;

    modport master (
        output cmd_valid, cmd_cr, cmd_addr, cmd_count, cmd_sel, abort,
        input  cmd_ready, i, i_en, load_data, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_cr, cmd_addr, cmd_count, cmd_sel, abort,
        output cmd_ready, i, i_en, load_data, busy, done
    );

endinterface

// File: rtl/instruction_sequencer_word_counter.sv
// Remaining-word down-counter (REM); saturates at zero so it can never wrap.
module seq_word_counter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          dec,
    output logic [DW-1:0] value,
    output logic          zero
);

    logic [DW-1:0] value_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_val;
        end else if (dec && (value_q != '0)) begin
            value_q <= value_q - 1'b1;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);

endmodule

// File: rtl/instruction_sequencer.sv
// Command-driven sequencer: loads CR/ADDR/COUNT into the datapath, then issues
// COUNT output/step instruction pairs and pulses DONE. Outputs are registered.
module instruction_sequencer
    import instr_seq_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    instruction_sequencer_if.slave  bus
);

    seq_state_e    state_q, state_d;
    logic [2:0]    cr_q, cr_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] count_q, count_d;
    logic [1:0]    sel_q, sel_d;

    logic          ready_q, busy_q, done_q, en_q;
    logic [2:0]    i_q;
    logic [DW-1:0] ld_q;

    logic          capture, abort_hit;
    logic          rem_load, rem_dec, rem_zero;
    logic [DW-1:0] rem_load_val, rem_value;

    assign capture   = bus.cmd_valid & ready_q;
    assign abort_hit = bus.abort && (state_q != S_IDLE) && (state_q != S_FIN);

    // Abort reuses the load path with zero so REM is cleared on the same edge.
    assign rem_load     = abort_hit || (state_q == S_LD_WORD);
    assign rem_load_val = abort_hit ? '0 : count_q;
    assign rem_dec      = (state_q == S_STEP);

    seq_word_counter #(.DW(DW)) u_rem (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rem_load),
        .load_val (rem_load_val),
        .dec      (rem_dec),
        .value    (rem_value),
        .zero     (rem_zero)
    );

    always_comb begin
        cr_d    = cr_q;
        addr_d  = addr_q;
        count_d = count_q;
        sel_d   = sel_q;
        if (capture) begin
            cr_d    = bus.cmd_cr;
            addr_d  = bus.cmd_addr;
            count_d = bus.cmd_count;
            sel_d   = bus.cmd_sel;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (capture) state_d = S_LD_CR;
            S_LD_CR:   state_d = S_LD_ADDR;
            S_LD_ADDR: state_d = S_LD_WORD;
            S_LD_WORD: state_d = (count_q != '0) ? S_OUT : S_FIN;
            S_OUT:     state_d = S_STEP;
            // REM still holds the pre-decrement value here.
            S_STEP:    state_d = (rem_zero || (rem_value == DW'(1))) ? S_FIN : S_OUT;
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (abort_hit) state_d = S_FIN;
    end

    // Outputs are computed from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cr_q    <= '0;
            addr_q  <= '0;
            count_q <= '0;
            sel_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            i_q     <= I_OUTA;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            cr_q    <= cr_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            sel_q   <= sel_d;
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_FIN);
            en_q    <= (state_d != S_IDLE) && (state_d != S_FIN);
            i_q     <= I_OUTA;
            ld_q    <= '0;
            case (state_d)
                S_LD_CR: begin
                    i_q  <= I_LDCR;
                    ld_q <= DW'(cr_d);
                end
                S_LD_ADDR: begin
                    i_q  <= I_LDAR;
                    ld_q <= addr_d;
                end
                S_LD_WORD: begin
                    i_q  <= I_LDWR;
                    ld_q <= count_d;
                end
                S_OUT:   i_q <= sel_to_code(sel_d);
                S_STEP:  i_q <= I_STEP;
                default: i_q <= I_OUTA;
            endcase
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.i_en      = en_q;
    assign bus.i         = i_q;
    assign bus.load_data = ld_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: each command pushes its expected
// per-cycle output trace, which is popped and compared cycle by cycle.
`timescale 1ns/1ps
module tb_instruction_sequencer;
    import instr_seq_pkg::*;

    localparam int DW = 8;

    typedef struct packed {
        logic          ready;
        logic          busy;
        logic          done;
        logic          en;
        logic [2:0]    i;
        logic [DW-1:0] ld;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    instruction_sequencer_if #(.DW(DW)) bus ();

    instruction_sequencer #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.ready = bus.cmd_ready;
        o.busy  = bus.busy;
        o.done  = bus.done;
        o.en    = bus.i_en;
        o.i     = bus.i;
        o.ld    = bus.load_data;
        return o;
    endfunction

    function automatic obs_t mk(input logic [2:0] i, input logic en, input logic done,
                                input logic [DW-1:0] ld);
        obs_t o;
        o.ready = 1'b0;
        o.busy  = 1'b1;
        o.done  = done;
        o.en    = en;
        o.i     = i;
        o.ld    = ld;
        return o;
    endfunction

    function automatic obs_t mk_idle();
        obs_t o;
        o.ready = 1'b1;
        o.busy  = 1'b0;
        o.done  = 1'b0;
        o.en    = 1'b0;
        o.i     = 3'b001;
        o.ld    = '0;
        return o;
    endfunction

    function automatic logic [2:0] out_code(input logic [1:0] sel);
        case (sel)
            2'b00:   return 3'b001;
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            default: return 3'b011;
        endcase
    endfunction

    // abort_at: 1-based cycle after capture during which ABORT is held high.
    task automatic push_cmd(input logic [2:0] cr, input logic [DW-1:0] addr,
                            input logic [DW-1:0] count, input logic [1:0] sel,
                            input int abort_at, output int n_steps);
        obs_t seq[$];
        seq.push_back(mk(3'b000, 1'b1, 1'b0, {{(DW-3){1'b0}}, cr}));
        seq.push_back(mk(3'b101, 1'b1, 1'b0, addr));
        seq.push_back(mk(3'b110, 1'b1, 1'b0, count));
        for (int k = 0; k < int'(count); k++) begin
            seq.push_back(mk(out_code(sel), 1'b1, 1'b0, '0));
            seq.push_back(mk(3'b111, 1'b1, 1'b0, '0));
        end
        if (abort_at >= 1) begin
            while (seq.size() > abort_at) void'(seq.pop_back());
        end
        seq.push_back(mk(3'b001, 1'b0, 1'b1, '0));
        n_steps = 0;
        foreach (seq[k]) begin
            if (seq[k].en && seq[k].i == 3'b111) n_steps++;
            exp_q.push_back(seq[k]);
        end
    endtask

    task automatic run_cmd(input logic [2:0] cr, input logic [DW-1:0] addr,
                           input logic [DW-1:0] count, input logic [1:0] sel,
                           input int abort_at = 0, input logic abort_idle = 1'b0,
                           input logic hold = 1'b0,
                           input logic [2:0] ncr = '0, input logic [DW-1:0] naddr = '0,
                           input logic [DW-1:0] ncount = '0, input logic [1:0] nsel = '0);
        int   wait_n = 0;
        int   j = 0;
        int   steps = 0;
        int   exp_steps;
        obs_t e;
        while (bus.cmd_ready !== 1'b1 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        chk("ready_wait", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_cr    = cr;
        bus.cmd_addr  = addr;
        bus.cmd_count = count;
        bus.cmd_sel   = sel;
        bus.abort     = abort_idle;
        push_cmd(cr, addr, count, sel, abort_at, exp_steps);
        @(posedge clk);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            j++;
            e = exp_q.pop_front();
            chk($sformatf("cyc%0d", j), 32'(sample()), 32'(e));
            if (bus.i_en && bus.i == 3'b111) steps++;
            bus.abort = (j == abort_at);
            if (hold) begin
                bus.cmd_cr    = ncr;
                bus.cmd_addr  = naddr;
                bus.cmd_count = ncount;
                bus.cmd_sel   = nsel;
            end else begin
                bus.cmd_valid = 1'b0;
            end
        end
        bus.abort = 1'b0;
        chk("steps", 32'(steps), 32'(exp_steps));
        @(negedge clk);
        chk("idle_after", 32'(sample()), 32'(mk_idle()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_cr    = '0;
        bus.cmd_addr  = '0;
        bus.cmd_count = '0;
        bus.cmd_sel   = '0;
        bus.abort     = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("reset", 32'(sample()), 32'(mk_idle()));
        @(negedge clk);
        rst_n = 1'b1;

        // Capture on the very first edge after release.
        run_cmd(3'b100, 8'h20, 8'd3, 2'b10);
        run_cmd(3'b001, 8'h55, 8'd0, 2'b01);

        // Held VALID with fields changing mid-command; the follow-up is captured next.
        run_cmd(3'b010, 8'h10, 8'd2, 2'b11, 0, 1'b0, 1'b1, 3'b011, 8'h99, 8'd1, 2'b00);
        run_cmd(3'b011, 8'h99, 8'd1, 2'b00);

        // Abort in second OUT, in LD_CR, in FIN (ignored), and in IDLE with capture.
        run_cmd(3'b100, 8'h40, 8'd5, 2'b10, 6);
        run_cmd(3'b101, 8'h41, 8'd3, 2'b11, 1);
        run_cmd(3'b110, 8'h42, 8'd1, 2'b01, 6);
        run_cmd(3'b111, 8'h43, 8'd2, 2'b10, 0, 1'b1);

        // Reset while in STEP of a COUNT=4 command.
        bus.cmd_valid = 1'b1;
        bus.cmd_cr    = 3'b001;
        bus.cmd_addr  = 8'h70;
        bus.cmd_count = 8'd4;
        bus.cmd_sel   = 2'b11;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_step", 32'(sample()), 32'(mk(3'b111, 1'b1, 1'b0, '0)));
        #1 rst_n = 1'b0;
        #1 chk("async_rst", 32'(sample()), 32'(mk_idle()));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d", k), 32'(sample()), 32'(mk_idle()));
        end

        for (int r = 0; r < 4; r++) begin
            run_cmd(3'($urandom_range(7)), 8'($urandom_range(255)),
                    8'($urandom_range(4)), 2'($urandom_range(3)));
        end

        run_cmd(3'b000, 8'hF0, 8'd255, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
